// File: rtl/tanh_pkg.sv
// rtl/tanh_pkg.sv - shared constants and types for the tanh coefficient streamer
// Purpose: coefficient width/depth defaults, Q1.15 series coefficient table and the
//          streamer FSM state encoding.
// Ports:   none (package).
package tanh_pkg;

  localparam int TANH_COEFF_W = 16;
  localparam int TANH_DEPTH   = 8;

  // Q1.15 two's complement series coefficients, index 0 first.
  localparam logic [TANH_COEFF_W-1:0] TANH_COEFF_TABLE [TANH_DEPTH] = '{
    16'h5555, 16'h6666, 16'h679E, 16'h67BD,
    16'h67C1, 16'h67C2, 16'h67C3, 16'h67C4
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } tanh_state_e;

endpackage

// File: rtl/tanh_coeff_rom.sv
// rtl/tanh_coeff_rom.sv - registered coefficient table read with enable
// Purpose: DATA_W x DEPTH coefficient table. Q1.15 source entries are left-aligned into
//          DATA_W bits; addresses beyond the source table read as 0. The output register
//          only updates when en_i is high.
// Ports:   clk, rst_n (async, active low), en_i (load enable), addr_i (table index),
//          data_o (registered coefficient).
module tanh_coeff_rom
  import tanh_pkg::*;
#(
  parameter int DATA_W = TANH_COEFF_W,
  parameter int DEPTH  = TANH_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);

  logic [TANH_COEFF_W-1:0]        raw;
  logic [DATA_W+TANH_COEFF_W-1:0] wide;
  logic [DATA_W-1:0]              data_d, data_q;

  always_comb begin
    raw = '0;
    for (int i = 0; i < TANH_DEPTH; i++) begin
      if (i < DEPTH && int'(addr_i) == i) begin
        raw = TANH_COEFF_TABLE[i];
      end
    end
  end

  // Keep the top DATA_W bits of the Q1.15 word: wider words gain zero LSBs, narrower
  // words drop LSBs, so the fractional value is preserved either way.
  assign wide = {raw, {DATA_W{1'b0}}};

  always_comb begin
    data_d = data_q;
    if (en_i) begin
      data_d = wide[DATA_W+TANH_COEFF_W-1 -: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/tanh_coeff_streamer.sv
// rtl/tanh_coeff_streamer.sv - streams N tanh series coefficients over valid/ready
// Purpose: on start, emits min(n_terms_i, DEPTH) coefficients in ascending or descending
//          index order, one per accepted handshake, then pulses done_o for one cycle.
// Ports:   clk, rst_n (async, active low); start_i/n_terms_i/descend_i (run request);
//          abort_i (cancel run); coeff_o/idx_o/last_o/valid_o with ready_i (output stream);
//          busy_o (run in progress), done_o (run completed pulse).
module tanh_coeff_streamer
  import tanh_pkg::*;
#(
  parameter int DATA_W  = TANH_COEFF_W,
  parameter int DEPTH   = TANH_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   n_terms_i,
  input  logic              descend_i,
  input  logic              abort_i,
  output logic [DATA_W-1:0] coeff_o,
  output logic [ADDR_W-1:0] idx_o,
  output logic              last_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  tanh_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;     // terms still to emit after the current one
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              desc_q, desc_d;

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [ADDR_W:0]   n_eff;
  logic [ADDR_W:0]   n_minus1;
  logic              handshake;

  assign n_eff     = (n_terms_i > DEPTH_CNT) ? DEPTH_CNT : n_terms_i;
  assign n_minus1  = n_eff - (ADDR_W+1)'(1);
  assign handshake = valid_q & ready_i;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = 1'b0;
    desc_d   = desc_q;
    rom_en   = 1'b0;
    rom_addr = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          desc_d = descend_i;
          if (n_eff == '0) begin
            // Empty run: nothing to stream, report completion straight away.
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_d    = descend_i ? n_minus1[ADDR_W-1:0] : '0;
            rom_addr = idx_d;
            rom_en   = 1'b1;
            cnt_d    = n_minus1[ADDR_W-1:0];
            valid_d  = 1'b1;
            last_d   = (n_minus1 == '0);
            state_d  = ST_STREAM;
          end
        end
      end

      ST_STREAM: begin
        if (abort_i) begin
          // Abort wins over a same-cycle handshake: that term is treated as not taken.
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (handshake) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d    = desc_q ? (idx_q - ADDR_W'(1)) : (idx_q + ADDR_W'(1));
            rom_addr = idx_d;
            rom_en   = 1'b1;
            cnt_d    = cnt_q - ADDR_W'(1);
            last_d   = (cnt_q == ADDR_W'(1));
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      desc_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      desc_q  <= desc_d;
    end
  end

  tanh_coeff_rom #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (rom_en),
    .addr_i (rom_addr),
    .data_o (coeff_o)
  );

  assign idx_o   = idx_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tanh_coeff_streamer.sv
// tb/tb_tanh_coeff_streamer.sv - scoreboard bench for tanh_coeff_streamer
module tb_tanh_coeff_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, descend_i, abort_i, ready_i;
  logic [3:0]  n_terms_i;
  logic [15:0] coeff_o;
  logic [2:0]  idx_o;
  logic        last_o, valid_o, busy_o, done_o;

  logic        start2, desc2, abort2, ready2;
  logic [4:0]  n2;
  logic [23:0] coeff2;
  logic [3:0]  idx2;
  logic        last2, valid2, busy2, done2;

  always #5 clk = ~clk;

  tanh_coeff_streamer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .n_terms_i(n_terms_i),
    .descend_i(descend_i), .abort_i(abort_i), .coeff_o(coeff_o), .idx_o(idx_o),
    .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  tanh_coeff_streamer #(.DATA_W(24), .DEPTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start_i(start2), .n_terms_i(n2),
    .descend_i(desc2), .abort_i(abort2), .coeff_o(coeff2), .idx_o(idx2),
    .last_o(last2), .valid_o(valid2), .ready_i(ready2), .busy_o(busy2), .done_o(done2)
  );

  logic [15:0] tbl [8] = '{16'h5555, 16'h6666, 16'h679E, 16'h67BD,
                           16'h67C1, 16'h67C2, 16'h67C3, 16'h67C4};

  typedef struct {
    logic [15:0] c;
    logic [2:0]  i;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_pending = 0;
  bit   done_next = 0;
  int   ready_mode = 0;

  bit          hold_v = 0;
  logic [15:0] hold_c;
  logic [2:0]  hold_i;
  logic        hold_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = toggle, 2 = random.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = ~ready_i;
        default: ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops expectations on every accepted term, checks stalls hold and done timing.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v    = 0;
        done_next = 0;
        continue;
      end
      if (hold_v) begin
        chk("hold_valid", 32'(valid_o), 32'd1);
        chk("hold_coeff", 32'(coeff_o), 32'(hold_c));
        chk("hold_idx", 32'(idx_o), 32'(hold_i));
        chk("hold_last", 32'(last_o), 32'(hold_l));
        hold_v = 0;
      end
      if (done_next) begin
        chk("done_after_last", 32'(done_o), 32'd1);
        done_next = 0;
      end
      if (done_o) begin
        total++;
        if (done_pending == 0) begin
          bad++;
          $display("FAIL unexpected_done actual=1 expected=0 t=%0t", $time);
        end else begin
          done_pending--;
        end
      end
      if (valid_o && !abort_i) begin
        if (ready_i) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_term actual_idx=%0d expected=none t=%0t", idx_o, $time);
          end else begin
            e = exp_q.pop_front();
            chk("term_coeff", 32'(coeff_o), 32'(e.c));
            chk("term_idx", 32'(idx_o), 32'(e.i));
            chk("term_last", 32'(last_o), 32'(e.l));
            if (e.l) done_next = 1;
          end
        end else begin
          hold_v = 1;
          hold_c = coeff_o;
          hold_i = idx_o;
          hold_l = last_o;
        end
      end
    end
  end

  task automatic start_run(input int n, input bit desc, input bit expect_done);
    exp_t e;
    int   nn;
    int   ix;
    nn = (n > 8) ? 8 : n;
    @(posedge clk);
    #1;
    start_i   = 1'b1;
    n_terms_i = 4'(n);
    descend_i = desc;
    for (int k = 0; k < nn; k++) begin
      ix  = desc ? (nn - 1 - k) : k;
      e.c = tbl[ix];
      e.i = 3'(ix);
      e.l = (k == nn - 1);
      exp_q.push_back(e);
    end
    if (expect_done) done_pending++;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(negedge clk);
    chk("first_valid", 32'(valid_o), 32'(nn > 0));
    chk("first_done", 32'(done_o), 32'(nn == 0));
  endtask

  task automatic wait_idle(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy_o || valid_o) && k < 400);
    chk("idle_timeout", 32'(busy_o | valid_o), 32'd0);
  endtask

  initial begin
    int cyc;
    int j;
    rst_n = 1'b0;
    start_i = 0; n_terms_i = 0; descend_i = 0; abort_i = 0;
    start2 = 0; n2 = 0; desc2 = 0; abort2 = 0; ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_coeff", 32'(coeff_o), 32'd0);
    chk("rst_idx", 32'(idx_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // 1: ascending, always ready -> 4 back-to-back terms, done one cycle later
    ready_mode = 0;
    start_run(4, 0, 1);
    wait_idle(cyc);
    chk("t1_cycles", 32'(cyc), 32'd5);

    // 2: descending with toggling ready
    ready_mode = 1;
    start_run(4, 1, 1);
    wait_idle(cyc);

    // 3: empty run and oversized run
    ready_mode = 0;
    start_run(0, 0, 1);
    wait_idle(cyc);
    chk("n0_cycles", 32'(cyc), 32'd1);
    start_run(9, 0, 1);
    wait_idle(cyc);
    chk("n9_cycles", 32'(cyc), 32'd9);

    // 4: abort on the second term
    start_run(4, 0, 0);
    @(posedge clk);
    #1;
    abort_i = 1'b1;
    @(posedge clk);
    #1;
    abort_i = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_valid", 32'(valid_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk);
    start_run(4, 1, 1);
    wait_idle(cyc);

    // 5a: start during STREAM is ignored
    ready_mode = 1;
    start_run(3, 0, 1);
    @(posedge clk);
    #1;
    start_i = 1'b1; n_terms_i = 4'd5; descend_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_idle(cyc);
    repeat (4) @(negedge clk);

    // 5b: asynchronous reset mid-stream
    start_run(6, 0, 1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_coeff", 32'(coeff_o), 32'd0);
    chk("arst_idx", 32'(idx_o), 32'd0);
    chk("arst_last", 32'(last_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    exp_q.delete();
    done_pending = 0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Randomized runs against the reference model
    for (int r = 0; r < 25; r++) begin
      ready_mode = $urandom_range(0, 2);
      start_run($urandom_range(0, 10), 1'($urandom_range(0, 1)), 1);
      wait_idle(cyc);
    end
    ready_mode = 0;
    repeat (3) @(negedge clk);

    // 6: 24-bit, 16-deep build, ascending full run
    @(posedge clk);
    #1;
    start2 = 1'b1;
    n2 = 5'd16;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    j = 0;
    for (int c = 0; c < 40 && j < 16; c++) begin
      @(negedge clk);
      if (valid2) begin
        chk("d16_coeff", 32'(coeff2), (j < 8) ? 32'({tbl[j], 8'h00}) : 32'd0);
        chk("d16_idx", 32'(idx2), 32'(j));
        chk("d16_last", 32'(last2), 32'(j == 15));
        j++;
      end
    end
    chk("d16_terms", 32'(j), 32'd16);
    @(negedge clk);
    chk("d16_done", 32'(done2), 32'd1);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_pending", 32'(done_pending), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
